// File: rtl/fsmc_master.sv
// FSMC mode-B multiplexed-bus initiator; done pulses ADDSET+ADDHLD+DATAST+BUSTURN cycles after acceptance.
// One access in flight; ready low while busy, and requests seen then are dropped rather than queued.
module fsmc_master #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16,
    parameter int ADDSET     = 2,
    parameter int ADDHLD     = 1,
    parameter int DATAST     = 4,
    parameter int BUSTURN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rd_data,
    inout  wire  [ADDR_WIDTH-1:0] AD,
    output logic                  NE,
    output logic                  NADV,
    output logic                  NWE,
    output logic                  NOE
);

    if (ADDSET < 1 || ADDHLD < 1 || DATAST < 1 || BUSTURN < 1) begin : g_param_err
        $error("fsmc_master: ADDSET, ADDHLD, DATAST and BUSTURN must all be >= 1");
    end

    localparam int MAX_AH = (ADDSET > ADDHLD) ? ADDSET : ADDHLD;
    localparam int MAX_DT = (DATAST > BUSTURN) ? DATAST : BUSTURN;
    localparam int MAXP   = (MAX_AH > MAX_DT) ? MAX_AH : MAX_DT;
    localparam int CW     = $clog2(MAXP + 1);

    localparam logic [CW-1:0] LD_ADDSET  = CW'(ADDSET - 1);
    localparam logic [CW-1:0] LD_ADDHLD  = CW'(ADDHLD - 1);
    localparam logic [CW-1:0] LD_DATAST  = CW'(DATAST - 1);
    localparam logic [CW-1:0] LD_BUSTURN = CW'(BUSTURN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        AHOLD = 3'd2,
        DATA  = 3'd3,
        TURN  = 3'd4
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [ADDR_WIDTH-1:0]   ad_out_q;
    logic                    ad_oe_q;
    logic                    ne_q, nadv_q, nwe_q, noe_q;
    logic                    ready_q, done_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            ad_out_q  <= '0;
            ad_oe_q   <= 1'b0;
            ne_q      <= 1'b1;
            nadv_q    <= 1'b1;
            nwe_q     <= 1'b1;
            noe_q     <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        wr_q     <= req_wr;
                        wdata_q  <= req_wdata;
                        ad_out_q <= req_addr;
                        ad_oe_q  <= 1'b1;
                        ne_q     <= 1'b0;
                        nadv_q   <= 1'b0;
                        ready_q  <= 1'b0;
                        cnt_q    <= LD_ADDSET;
                        state_q  <= ADDR;
                    end
                end
                ADDR: begin
                    if (cnt_q == '0) begin
                        nadv_q  <= 1'b1;
                        cnt_q   <= LD_ADDHLD;
                        state_q <= AHOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                AHOLD: begin
                    if (cnt_q == '0) begin
                        // Read releases AD on the same edge that asserts NOE, so the slave never sees contention.
                        if (wr_q) begin
                            nwe_q    <= 1'b0;
                            ad_out_q <= ADDR_WIDTH'(wdata_q);
                        end else begin
                            noe_q   <= 1'b0;
                            ad_oe_q <= 1'b0;
                        end
                        cnt_q   <= LD_DATAST;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        if (!wr_q) begin
                            rd_data_q <= AD[DATA_WIDTH-1:0];
                        end
                        ne_q    <= 1'b1;
                        nwe_q   <= 1'b1;
                        noe_q   <= 1'b1;
                        cnt_q   <= LD_BUSTURN;
                        state_q <= TURN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                TURN: begin
                    // Write data is held for exactly the first turnaround cycle.
                    ad_oe_q <= 1'b0;
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign AD      = ad_oe_q ? ad_out_q : 'z;
    assign NE      = ne_q;
    assign NADV    = nadv_q;
    assign NWE     = nwe_q;
    assign NOE     = noe_q;
    assign ready   = ready_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;

endmodule
